decode_ctrl_stage: RTL and testbench

Registered, handshaked successor to the combinational main control decoder. It sits between fetch and execute and replaces the stall-masked combinational decode with a one-entry pipeline register using valid/ready flow control. Strict funct-field legality checking and the M extension are selectable by parameter. A small sequencer splits read-modify-write atomics (AMO*.W) into a read micro-op followed by a write micro-op.

---
 rtl/decode_ctrl_stage.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage
//   Registered main-control decoder between fetch and execute. It holds one
//   entry in a pipeline register and uses valid/ready flow control. AMO*.W
//   atomics are split into a read micro-op followed by a write micro-op.
//
// Parameters:
//   M_EXT  - 1: RV32M (R-type, funct7=0000001) is legal and sets o_ALUM_en.
//            0: those encodings are illegal.
//   STRICT - 1: funct3/funct7 legality is checked per opcode.
//            0: only the opcode is checked.
// Build option:
//   ARVI_AMO_EN - when defined, AMO funct5 values decode as two-phase and the
//                 AMO_RD/AMO_WR states exist. When undefined, only LR/SC are
//                 legal atomics and o_AMO_phase is always 0.
// Ports:
//   i_clk, i_rstn        clock (rising edge), async active-low reset
//   i_Instr, i_Valid     instruction from fetch and its valid flag
//   o_Ready              stage accepts i_Instr this cycle (combinational)
//   o_Valid, i_Ready     output bundle valid / consumed by execute
//   i_Flush              drop the held entry and abort any AMO sequence
//   o_Instr              instruction belonging to the current bundle
//   o_Branch..o_atomic   single-bit controls
//   o_ALUOp, o_ALUSrcA, o_Jump   multi-bit control fields
//   o_AMO_phase          0 = read/single micro-op, 1 = AMO write micro-op
module decode_ctrl_stage #(
    parameter int M_EXT  = 1,
    parameter int STRICT = 1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [31:0] i_Instr,
    input  logic        i_Valid,
    output logic        o_Ready,
    output logic        o_Valid,
    input  logic        i_Ready,
    input  logic        i_Flush,
    output logic [31:0] o_Instr,
    output logic        o_Branch,
    output logic        o_MemRead,
    output logic        o_MemWrite,
    output logic        o_MemToReg,
    output logic        o_ALUSrcB,
    output logic        o_RegWrite,
    output logic        o_PCplus4,
    output logic        o_CSR_en,
    output logic        o_Ex_inst_illegal,
    output logic        o_ALUM_en,
    output logic        o_atomic,
    output logic [2:0]  o_ALUOp,
    output logic [1:0]  o_ALUSrcA,
    output logic [1:0]  o_Jump,
    output logic        o_AMO_phase
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_ATOMIC = 7'b0101111;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src_b;
        logic       reg_write;
        logic       pc_plus4;
        logic       csr_en;
        logic       illegal;
        logic       alum_en;
        logic       atomic;
        logic [2:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] jump;
        logic       amo_phase;
    } ctrl_t;

`ifdef ARVI_AMO_EN
    typedef enum logic [1:0] {EMPTY, FULL, AMO_RD, AMO_WR} state_t;
`else
    typedef enum logic {EMPTY, FULL} state_t;
`endif

    state_t      state;
    ctrl_t       ctrl_q;
    ctrl_t       dec_ctrl;
    logic [31:0] instr_q;
    logic        legal;
    logic        amo_hold;
    logic        accept;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] funct5;

    assign opcode = i_Instr[6:0];
    assign funct3 = i_Instr[14:12];
    assign funct7 = i_Instr[31:25];
    assign funct5 = i_Instr[31:27];

`ifdef ARVI_AMO_EN
    logic  dec_two_phase;
    ctrl_t amo_wr_ctrl;

    always_comb begin
        amo_wr_ctrl           = '0;
        amo_wr_ctrl.mem_write = 1'b1;
        amo_wr_ctrl.atomic    = 1'b1;
        amo_wr_ctrl.alu_op    = 3'b101;
        amo_wr_ctrl.amo_phase = 1'b1;
    end

    assign amo_hold = (state == AMO_RD);
`else
    assign amo_hold = 1'b0;
`endif

    always_comb begin
        dec_ctrl = '0;
        legal    = 1'b1;
`ifdef ARVI_AMO_EN
        dec_two_phase = 1'b0;
`endif
        case (opcode)
            OP_R: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = 3'b010;
                // An M encoding without the extension is never executable,
                // so it is rejected even when STRICT is off.
                if (funct7 == 7'b0000001) begin
                    if (M_EXT != 0) dec_ctrl.alum_en = 1'b1;
                    else            legal = 1'b0;
                end else if (STRICT != 0) begin
                    if (!((funct7 == 7'b0000000) ||
                          (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
                        legal = 1'b0;
                end
            end
            OP_I: begin
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = 3'b011;
                if (STRICT != 0) begin
                    if (funct3 == 3'b001 && funct7 != 7'b0000000) legal = 1'b0;
                    if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
                        legal = 1'b0;
                end
            end
            OP_LOAD: begin
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.alu_src_b  = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                if (STRICT != 0 && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
                    legal = 1'b0;
            end
            OP_STORE: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src_b = 1'b1;
                if (STRICT != 0 && funct3 > 3'b010) legal = 1'b0;
            end
            OP_BRANCH: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu_op = 3'b001;
                if (STRICT != 0 && (funct3 == 3'b010 || funct3 == 3'b011)) legal = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                dec_ctrl.alu_src_a = (opcode == OP_LUI) ? 2'd2 : 2'd1;
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = 3'b100;
            end
            OP_JAL: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.jump      = 2'd1;
                dec_ctrl.pc_plus4  = 1'b1;
            end
            OP_JALR: begin
                dec_ctrl.alu_src_b = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = 3'b100;
                dec_ctrl.jump      = 2'd2;
                dec_ctrl.pc_plus4  = 1'b1;
                if (STRICT != 0 && funct3 != 3'b000) legal = 1'b0;
            end
            OP_FENCE: ;
            OP_SYSTEM: begin
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.csr_en     = 1'b1;
            end
            OP_ATOMIC: begin
                dec_ctrl.atomic     = 1'b1;
                dec_ctrl.alu_op     = 3'b101;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                if (STRICT != 0 && funct3 != 3'b010) legal = 1'b0;
                if (funct5 == 5'b00011) begin
                    dec_ctrl.mem_write = 1'b1;
                end else if (funct5 != 5'b00010) begin
`ifdef ARVI_AMO_EN
                    // Phase 0 of an AMO; the write micro-op is built by the sequencer.
                    dec_two_phase = 1'b1;
                    if (STRICT != 0) begin
                        case (funct5)
                            5'b00000, 5'b00001, 5'b00100, 5'b01000, 5'b01100,
                            5'b10000, 5'b10100, 5'b11000, 5'b11100: ;
                            default: legal = 1'b0;
                        endcase
                    end
`else
                    legal = 1'b0;
`endif
                end
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec_ctrl         = '0;
            dec_ctrl.illegal = 1'b1;
`ifdef ARVI_AMO_EN
            dec_two_phase    = 1'b0;
`endif
        end
    end

    assign o_Valid = (state != EMPTY);
    assign o_Ready = !amo_hold && (!o_Valid || i_Ready) && !i_Flush;
    assign accept  = i_Valid && o_Ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= EMPTY;
            ctrl_q  <= '0;
            instr_q <= '0;
        end else if (i_Flush) begin
            state  <= EMPTY;
            ctrl_q <= '0;
`ifdef ARVI_AMO_EN
        end else if (state == AMO_RD) begin
            if (i_Ready) begin
                state  <= AMO_WR;
                ctrl_q <= amo_wr_ctrl;
            end
`endif
        end else if (accept) begin
            ctrl_q  <= dec_ctrl;
            instr_q <= i_Instr;
`ifdef ARVI_AMO_EN
            state   <= dec_two_phase ? AMO_RD : FULL;
`else
            state   <= FULL;
`endif
        end else if (o_Valid && i_Ready) begin
            state  <= EMPTY;
            ctrl_q <= '0;
        end
    end

    assign o_Instr           = instr_q;
    assign o_Branch          = ctrl_q.branch;
    assign o_MemRead         = ctrl_q.mem_read;
    assign o_MemWrite        = ctrl_q.mem_write;
    assign o_MemToReg        = ctrl_q.mem_to_reg;
    assign o_ALUSrcB         = ctrl_q.alu_src_b;
    assign o_RegWrite        = ctrl_q.reg_write;
    assign o_PCplus4         = ctrl_q.pc_plus4;
    assign o_CSR_en          = ctrl_q.csr_en;
    assign o_Ex_inst_illegal = ctrl_q.illegal;
    assign o_ALUM_en         = ctrl_q.alum_en;
    assign o_atomic          = ctrl_q.atomic;
    assign o_ALUOp           = ctrl_q.alu_op;
    assign o_ALUSrcA         = ctrl_q.alu_src_a;
    assign o_Jump            = ctrl_q.jump;
    assign o_AMO_phase       = ctrl_q.amo_phase;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage
//   Directed bench for decode_ctrl_stage. A second instance with M_EXT=0
//   shares the same stimulus to cover the M-extension legality difference.
//   The AMO sections follow the ARVI_AMO_EN build option.
module tb_decode_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_Instr;
    logic        i_Valid, i_Ready, i_Flush;

    logic        o_Ready, o_Valid;
    logic [31:0] o_Instr;
    logic        o_Branch, o_MemRead, o_MemWrite, o_MemToReg, o_ALUSrcB, o_RegWrite;
    logic        o_PCplus4, o_CSR_en, o_Ex_inst_illegal, o_ALUM_en, o_atomic, o_AMO_phase;
    logic [2:0]  o_ALUOp;
    logic [1:0]  o_ALUSrcA, o_Jump;

    logic        nm_Ready, nm_Valid;
    logic [31:0] nm_Instr;
    logic        nm_Branch, nm_MemRead, nm_MemWrite, nm_MemToReg, nm_ALUSrcB, nm_RegWrite;
    logic        nm_PCplus4, nm_CSR_en, nm_illegal, nm_ALUM_en, nm_atomic, nm_AMO_phase;
    logic [2:0]  nm_ALUOp;
    logic [1:0]  nm_ALUSrcA, nm_Jump;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Control vector bit positions: {Branch, MemRead, MemWrite, MemToReg,
    // ALUSrcB, RegWrite, PCplus4, CSR_en, illegal, ALUM_en, atomic,
    // ALUOp[2:0], ALUSrcA[1:0], Jump[1:0], AMO_phase}
    localparam logic [18:0] BR  = 19'h40000;
    localparam logic [18:0] MR  = 19'h20000;
    localparam logic [18:0] MW  = 19'h10000;
    localparam logic [18:0] M2R = 19'h08000;
    localparam logic [18:0] SB  = 19'h04000;
    localparam logic [18:0] RW  = 19'h02000;
    localparam logic [18:0] PC4 = 19'h01000;
    localparam logic [18:0] CSR = 19'h00800;
    localparam logic [18:0] ILL = 19'h00400;
    localparam logic [18:0] MUL = 19'h00200;
    localparam logic [18:0] AT  = 19'h00100;
    localparam logic [18:0] PH  = 19'h00001;

    localparam logic [31:0] I_ADD    = 32'h003100B3;
    localparam logic [31:0] I_LW     = 32'h0000A083;
    localparam logic [31:0] I_SW     = 32'h0020A023;
    localparam logic [31:0] I_ADDI   = 32'h00108093;
    localparam logic [31:0] I_AMOADD = 32'h0063A2AF;

    logic [18:0] ctl;
    assign ctl = {o_Branch, o_MemRead, o_MemWrite, o_MemToReg, o_ALUSrcB, o_RegWrite,
                  o_PCplus4, o_CSR_en, o_Ex_inst_illegal, o_ALUM_en, o_atomic,
                  o_ALUOp, o_ALUSrcA, o_Jump, o_AMO_phase};

    function automatic logic [18:0] aluop(input logic [2:0] v);
        return {11'b0, v, 5'b0};
    endfunction
    function automatic logic [18:0] srca(input logic [1:0] v);
        return {14'b0, v, 3'b0};
    endfunction
    function automatic logic [18:0] jmp(input logic [1:0] v);
        return {16'b0, v, 1'b0};
    endfunction

    decode_ctrl_stage dut (
        .i_clk(clk), .i_rstn(rst_n), .i_Instr(i_Instr), .i_Valid(i_Valid),
        .o_Ready(o_Ready), .o_Valid(o_Valid), .i_Ready(i_Ready), .i_Flush(i_Flush),
        .o_Instr(o_Instr), .o_Branch(o_Branch), .o_MemRead(o_MemRead),
        .o_MemWrite(o_MemWrite), .o_MemToReg(o_MemToReg), .o_ALUSrcB(o_ALUSrcB),
        .o_RegWrite(o_RegWrite), .o_PCplus4(o_PCplus4), .o_CSR_en(o_CSR_en),
        .o_Ex_inst_illegal(o_Ex_inst_illegal), .o_ALUM_en(o_ALUM_en),
        .o_atomic(o_atomic), .o_ALUOp(o_ALUOp), .o_ALUSrcA(o_ALUSrcA),
        .o_Jump(o_Jump), .o_AMO_phase(o_AMO_phase)
    );

    decode_ctrl_stage #(.M_EXT(0), .STRICT(1)) dut_nm (
        .i_clk(clk), .i_rstn(rst_n), .i_Instr(i_Instr), .i_Valid(i_Valid),
        .o_Ready(nm_Ready), .o_Valid(nm_Valid), .i_Ready(i_Ready), .i_Flush(i_Flush),
        .o_Instr(nm_Instr), .o_Branch(nm_Branch), .o_MemRead(nm_MemRead),
        .o_MemWrite(nm_MemWrite), .o_MemToReg(nm_MemToReg), .o_ALUSrcB(nm_ALUSrcB),
        .o_RegWrite(nm_RegWrite), .o_PCplus4(nm_PCplus4), .o_CSR_en(nm_CSR_en),
        .o_Ex_inst_illegal(nm_illegal), .o_ALUM_en(nm_ALUM_en),
        .o_atomic(nm_atomic), .o_ALUOp(nm_ALUOp), .o_ALUSrcA(nm_ALUSrcA),
        .o_Jump(nm_Jump), .o_AMO_phase(nm_AMO_phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction with the consumer ready and check the bundle
    // shown after the accepting edge.
    task automatic run_vec(input string tag, input logic [31:0] instr, input logic [18:0] exp);
        i_Instr = instr;
        i_Valid = 1'b1;
        i_Ready = 1'b1;
        tick();
        check({tag, "_ctl"}, {13'b0, ctl}, {13'b0, exp});
        check({tag, "_instr"}, o_Instr, instr);
        check({tag, "_valid"}, {31'b0, o_Valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        i_Instr = '0;
        i_Valid = 1'b0;
        i_Ready = 1'b0;
        i_Flush = 1'b0;
        #12;
        check("rst_valid", {31'b0, o_Valid}, 32'd0);
        check("rst_ctl", {13'b0, ctl}, 32'd0);
        check("rst_instr", o_Instr, 32'd0);
        check("rst_ready", {31'b0, o_Ready}, 32'd1);
        rst_n = 1'b1;

        run_vec("add", I_ADD, RW | aluop(3'b010));
        // Simultaneous handshake of ADD and accept of LW.
        run_vec("lw", I_LW, MR | M2R | SB | RW);

        i_Ready = 1'b0;
        i_Instr = I_SW;
        #1;
        check("stall_ready", {31'b0, o_Ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ctl", {13'b0, ctl}, {13'b0, MR | M2R | SB | RW});
            check("stall_instr", o_Instr, I_LW);
            check("stall_ready_hold", {31'b0, o_Ready}, 32'd0);
        end
        i_Ready = 1'b1;
        #1;
        check("release_ready", {31'b0, o_Ready}, 32'd1);
        tick();
        check("handover_instr", o_Instr, I_SW);
        check("handover_ctl", {13'b0, ctl}, {13'b0, MW | SB});
        check("handover_valid", {31'b0, o_Valid}, 32'd1);

        run_vec("beq",      32'h00208063, BR | aluop(3'b001));
        run_vec("lui",      32'h123450B7, srca(2'd2) | SB | RW | aluop(3'b100));
        run_vec("auipc",    32'h00001097, srca(2'd1) | SB | RW | aluop(3'b100));
        run_vec("jal",      32'h008000EF, RW | jmp(2'd1) | PC4);
        run_vec("jalr",     32'h000080E7, SB | RW | aluop(3'b100) | jmp(2'd2) | PC4);
        run_vec("fence",    32'h0FF0000F, 19'h0);
        run_vec("csrrw",    32'h30529073, M2R | RW | CSR);
        run_vec("sub",      32'h402080B3, RW | aluop(3'b010));
        run_vec("sll_f7",   32'h402090B3, ILL);
        run_vec("addi",     I_ADDI,       SB | RW | aluop(3'b011));
        run_vec("srai",     32'h4010D093, SB | RW | aluop(3'b011));
        run_vec("slli_f7",  32'h40109093, ILL);
        run_vec("ld",       32'h0000B083, ILL);
        run_vec("sd",       32'h0020B023, ILL);
        run_vec("br_f3",    32'h0020A063, ILL);
        run_vec("jalr_f3",  32'h000090E7, ILL);
        run_vec("lr",       32'h1003A2AF, MR | M2R | RW | AT | aluop(3'b101));
        run_vec("sc",       32'h1853A2AF, MR | MW | M2R | RW | AT | aluop(3'b101));
        run_vec("amo_f3",   32'h0063B2AF, ILL);

        run_vec("mul", 32'h023100B3, RW | aluop(3'b010) | MUL);
        check("mul_nm_ill", {31'b0, nm_illegal}, 32'd1);
        check("mul_nm_alum", {31'b0, nm_ALUM_en}, 32'd0);
        run_vec("zero", 32'h00000000, ILL);
        check("zero_nm_ill", {31'b0, nm_illegal}, 32'd1);

        i_Valid = 1'b0;
        tick();
        check("drain_valid", {31'b0, o_Valid}, 32'd0);
        check("drain_ctl", {13'b0, ctl}, 32'd0);

`ifdef ARVI_AMO_EN
        run_vec("amo_rd", I_AMOADD, MR | M2R | RW | AT | aluop(3'b101));
        i_Instr = I_ADDI;
        #1;
        check("amo_rd_ready", {31'b0, o_Ready}, 32'd0);
        tick();
        check("amo_wr_ctl", {13'b0, ctl}, {13'b0, MW | AT | aluop(3'b101) | PH});
        check("amo_wr_instr", o_Instr, I_AMOADD);
        check("amo_wr_ready", {31'b0, o_Ready}, 32'd1);
        tick();
        check("after_amo_ctl", {13'b0, ctl}, {13'b0, SB | RW | aluop(3'b011)});
        check("after_amo_instr", o_Instr, I_ADDI);

        run_vec("flush_amo", I_AMOADD, MR | M2R | RW | AT | aluop(3'b101));
`else
        run_vec("amo_ill", I_AMOADD, ILL);
        run_vec("flush_lw", I_LW, MR | M2R | SB | RW);
`endif
        i_Instr = I_ADDI;
        i_Flush = 1'b1;
        #1;
        check("flush_ready_low", {31'b0, o_Ready}, 32'd0);
        tick();
        check("flush_valid", {31'b0, o_Valid}, 32'd0);
        check("flush_ctl", {13'b0, ctl}, 32'd0);
        i_Flush = 1'b0;
        i_Valid = 1'b0;
        #1;
        check("flush_ready", {31'b0, o_Ready}, 32'd1);

`ifdef ARVI_AMO_EN
        run_vec("rst_amo", I_AMOADD, MR | M2R | RW | AT | aluop(3'b101));
`else
        run_vec("rst_lw", I_LW, MR | M2R | SB | RW);
`endif
        i_Valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, o_Valid}, 32'd0);
        check("async_rst_ctl", {13'b0, ctl}, 32'd0);
        check("async_rst_instr", o_Instr, 32'd0);
        #10;
        rst_n = 1'b1;
        #10;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
